// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register block fronting a job-based IP core: operand/result
// registers, a START/BUSY/DONE/TIMEOUT job tracker and the core handshake.
module custom_axi_ip_regs #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [63:0]           hw_data_o,
    output logic                  hw_enable_o,
    input  logic [63:0]           hw_data_i,
    input  logic                  hw_wen_i,
    input  logic [1:0]            hw_status_i
);

    localparam int unsigned IW = ADDR_WIDTH - 2;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] ST_BUSY     = 2'd1;

    localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS  = IW'(1);
    localparam logic [IW-1:0] IDX_DATA_LO = IW'(2);
    localparam logic [IW-1:0] IDX_DATA_HI = IW'(3);
    localparam logic [IW-1:0] IDX_RES_LO  = IW'(4);
    localparam logic [IW-1:0] IDX_RES_HI  = IW'(5);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    logic [0:0]  w_state_q, r_state_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] data_lo_q, data_lo_d, data_hi_q, data_hi_d;
    logic [31:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic [1:0]  status_q;
    logic        done_q, done_d, busy_q, busy_d, timeout_q, timeout_d;
    logic        hw_en_q, hw_en_d;
    logic [15:0] cnt_q, cnt_d;

    logic        wr_fire, wr_aligned, rd_aligned, start_req;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_val, status_word;
    logic [IW-1:0] aw_idx, ar_idx;

    assign aw_idx      = s_axi_awaddr[ADDR_WIDTH-1:2];
    assign ar_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
    assign wr_aligned  = (s_axi_awaddr[1:0] == 2'b00);
    assign rd_aligned  = (s_axi_araddr[1:0] == 2'b00);
    assign status_word = {27'd0, timeout_q, busy_q, done_q, status_q};

    assign wr_fire       = (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign hw_data_o     = {data_hi_q, data_lo_q};
    assign hw_enable_o   = hw_en_q;

    // Write decode: byte-strobed operand updates, START request, response code
    always_comb begin
        wr_resp   = RESP_SLVERR;
        data_lo_d = data_lo_q;
        data_hi_d = data_hi_q;
        start_req = 1'b0;
        if (wr_fire && wr_aligned) begin
            if (aw_idx == IDX_CTRL) begin
                wr_resp = RESP_OKAY;
                if (s_axi_wstrb[0] && s_axi_wdata[0]) begin
                    // A write-back landing this cycle wins over a new launch
                    if (busy_q || hw_wen_i) wr_resp = RESP_SLVERR;
                    else                    start_req = 1'b1;
                end
            end else if (aw_idx == IDX_DATA_LO) begin
                wr_resp = RESP_OKAY;
                for (int unsigned b = 0; b < 4; b++)
                    if (s_axi_wstrb[b]) data_lo_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
            end else if (aw_idx == IDX_DATA_HI) begin
                wr_resp = RESP_OKAY;
                for (int unsigned b = 0; b < 4; b++)
                    if (s_axi_wstrb[b]) data_hi_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Job tracker: launch, core handshake, write-back capture and timeout
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        hw_en_d   = hw_en_q;
        cnt_d     = cnt_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        if (busy_q) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == TMO) begin
                busy_d    = 1'b0;
                timeout_d = 1'b1;
                hw_en_d   = 1'b0;
            end
        end
        if (hw_en_q && status_q == ST_BUSY) hw_en_d = 1'b0;
        if (start_req) begin
            busy_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            cnt_d     = '0;
            hw_en_d   = 1'b1;
        end
        if (hw_wen_i) begin
            res_lo_d = hw_data_i[31:0];
            res_hi_d = hw_data_i[63:32];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            hw_en_d  = 1'b0;
            cnt_d    = cnt_q;
        end
    end

    // Read decode: current (pre-edge) register contents for the addressed word
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_SLVERR;
        if (rd_aligned) begin
            rd_resp = RESP_OKAY;
            if      (ar_idx == IDX_CTRL)    rd_val = '0;
            else if (ar_idx == IDX_STATUS)  rd_val = status_word;
            else if (ar_idx == IDX_DATA_LO) rd_val = data_lo_q;
            else if (ar_idx == IDX_DATA_HI) rd_val = data_hi_q;
            else if (ar_idx == IDX_RES_LO)  rd_val = res_lo_q;
            else if (ar_idx == IDX_RES_HI)  rd_val = res_hi_q;
            else                            rd_resp = RESP_SLVERR;
        end
    end

    // Write channel FSM: accept AW+W together, hold B until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            bresp_q   <= '0;
        end else if (w_state_q == W_IDLE) begin
            if (wr_fire) begin
                bresp_q   <= wr_resp;
                w_state_q <= W_RESP;
            end
        end else if (s_axi_bready) begin
            w_state_q <= W_IDLE;
        end
    end

    // Read channel FSM: capture data on address accept, hold R until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else if (r_state_q == R_IDLE) begin
            if (s_axi_arvalid) begin
                rdata_q   <= rd_val;
                rresp_q   <= rd_resp;
                r_state_q <= R_DATA;
            end
        end else if (s_axi_rready) begin
            r_state_q <= R_IDLE;
        end
    end

    // Register file and job state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_lo_q <= '0;
            data_hi_q <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            status_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hw_en_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            data_lo_q <= data_lo_d;
            data_hi_q <= data_hi_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            status_q  <= hw_status_i;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hw_en_q   <= hw_en_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/custom_axi_ip_regs.md
CUSTOM_AXI_IP_REGS -- requirements
Module: custom_axi_ip_regs

Interface
REQ-001 Parameter: ADDR_WIDTH, 5, AXI4-Lite byte address width.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, maximum cycles from job launch to result write-back (1..65535).
REQ-003 clk_i  in  1  single clock for all logic.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-006 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-008 s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-009 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 hw_data_o  out  64  job operand, always {DATA_HI, DATA_LO}.
REQ-011 hw_enable_o  out  1  job request level to the IP core.
REQ-012 hw_data_i  in  64  result from core, valid when hw_wen_i=1.
REQ-013 hw_wen_i  in  1  result write-back strobe.
REQ-014 hw_status_i  in  2  core status_e: IDLE=0, BUSY=1, DONE=2, ERROR=3.

Function
REQ-015 Register map (32-bit, word aligned): 0x00 CTRL (W: bit0 START, reads 0), 0x04 STATUS (RO), 0x08 DATA_LO (RW), 0x0C DATA_HI (RW), 0x10 RES_LO (RO), 0x14 RES_HI (RO).
REQ-016 STATUS: [1:0] hw_status_i registered each cycle, [2] DONE sticky, [3] BUSY, [4] TIMEOUT sticky, [31:5] zero.
REQ-017 Write FSM W_IDLE/W_RESP: in W_IDLE awready=wready=1 only when awvalid&wvalid both high; both accepted same cycle, register updated that edge, then W_RESP with bvalid=1 held until bready.
REQ-018 Read FSM R_IDLE/R_DATA: in R_IDLE arready=1; on arvalid, rdata captured next edge, R_DATA with rvalid=1 held stable until rready.
REQ-019 RW registers honour wstrb per byte; wstrb=0 writes nothing, bresp OKAY.
REQ-020 Unmapped address (read or write) and writes to STATUS/RES_* -> resp SLVERR (2'b10), no state change; unmapped reads return 0.
REQ-021 START=1 accepted only when BUSY=0 (pre-edge value): sets BUSY, clears DONE and TIMEOUT, loads timeout counter to 0, asserts hw_enable_o; bresp OKAY.
REQ-022 START=1 while BUSY=1 -> ignored, bresp SLVERR; CTRL write with START=0 -> OKAY, no effect.
REQ-023 hw_enable_o stays 1 until registered hw_status_i==BUSY is observed or hw_wen_i=1, whichever first, then drops next edge.
REQ-024 hw_wen_i=1: RES_HI/RES_LO <= hw_data_i[63:32]/[31:0], DONE<=1, BUSY<=0, counter stops; applies even when BUSY=0 (spurious write-back still captured).
REQ-025 While BUSY, counter increments each cycle; reaching TIMEOUT_CYCLES without hw_wen_i -> BUSY<=0, TIMEOUT<=1, hw_enable_o<=0, RES unchanged.
REQ-026 hw_wen_i and a START write in same cycle: write-back applied, START rejected (SLVERR).
REQ-027 Read of RES_*/STATUS in the cycle hw_wen_i arrives returns pre-update value.
REQ-028 Read and write channels operate concurrently and independently.
REQ-029 Write to DATA_* while BUSY permitted; hw_data_o follows immediately (core samples at launch only).

Reset
REQ-030 On rst_ni=0, asynchronously: all registers 0, both FSMs IDLE, awready/wready/bvalid/rvalid/hw_enable_o=0, bresp/rresp=0, rdata=0, counter 0.
REQ-031 Reset mid-transaction drops any pending bvalid/rvalid without response; mid-job reset clears BUSY and deasserts hw_enable_o.

Verification
REQ-032 Write DATA_LO=0x0000_0005, DATA_HI=0x0000_0007 -> hw_data_o=0x0000_0007_0000_0005, two OKAY responses.
REQ-033 START, core model replies hw_status_i=BUSY then hw_wen_i with 0x0000_0006_0000_0006 -> hw_enable_o deasserts after BUSY seen; RES_LO=6, RES_HI=6, STATUS=0x4 bits DONE set, BUSY clear.
REQ-034 START with core never responding, TIMEOUT_CYCLES=255 -> BUSY clears 255 cycles after launch, STATUS[4]=1, RES unchanged.
REQ-035 Second START while BUSY -> bresp=SLVERR, single job observed on hw_enable_o.
REQ-036 Read 0x18 -> rresp=SLVERR, rdata=0; write RES_LO -> SLVERR, value unchanged; bready held low 5 cycles -> bvalid stays high, no new write accepted.
REQ-037 Assert rst_ni=0 between clock edges during BUSY with rvalid pending -> outputs zero immediately, STATUS reads 0 after release.
